// File: rtl/yuv422_pkg.sv
// Shared YUV422 definitions for the frame buffer write and read sides:
// writer FSM states, pixel layout and the UYVY word packing.
package yuv422_pkg;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    PIX0     = 2'd1,
    PIX1     = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] chroma;
    logic [7:0] luma;
  } pixel_t;

  // byte0 = U, byte1 = Y0, byte2 = V, byte3 = Y1
  function automatic logic [31:0] pack_uyvy(input pixel_t p0, input pixel_t p1);
    return {p1.luma, p1.chroma, p0.luma, p0.chroma};
  endfunction

endpackage

// File: rtl/yuv422_fb_writer.sv
// Packs a valid/ready stream of 16-bit YUV422 pixels into 32-bit UYVY words
// and drives the frame buffer write port, resynchronising on start-of-frame.
module yuv422_fb_writer
  import yuv422_pkg::*;
#(
  parameter  int PIXELS   = 1280*760,
  localparam int ADR_BITS = $clog2(PIXELS)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                en_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  input  logic                s_sof_i,
  input  logic [15:0]         s_data_i,
  output logic [ADR_BITS-1:0] wr_addr_o,
  output logic [31:0]         wr_d_o,
  output logic                wr_en_o,
  output logic                frame_done_o,
  output logic                sync_err_o,
  output logic [1:0]          dbg_state_o
);

  // Handshake: a beat transfers on a rising clk_i edge where s_valid_i and
  // s_ready_o are both high; s_ready_o is en_i, the write port never stalls.

  localparam int WORDS = PIXELS / 2;
  localparam logic [ADR_BITS-1:0] LAST_WORD = ADR_BITS'(WORDS - 1);

  state_t              r_state;
  state_t              w_next_state;
  pixel_t              r_hold;
  logic [ADR_BITS-1:0] r_cnt;
  logic                w_accept;
  logic                w_last;
  logic                w_load_hold;
  logic                w_issue;
  logic                w_err;
  logic                w_cnt_clr;

  assign s_ready_o   = en_i;
  assign w_accept    = s_valid_i & en_i;
  assign w_last      = (r_cnt == LAST_WORD);
  assign dbg_state_o = r_state;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= WAIT_SOF;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load_hold  = 1'b0;
    w_issue      = 1'b0;
    w_err        = 1'b0;
    w_cnt_clr    = 1'b0;
    if (w_accept) begin
      case (r_state)
        WAIT_SOF: begin
          if (s_sof_i) begin
            w_load_hold  = 1'b1;
            w_cnt_clr    = 1'b1;
            w_next_state = PIX1;
          end
        end
        PIX0: begin
          w_load_hold  = 1'b1;
          w_next_state = PIX1;
          if (s_sof_i) begin
            w_err     = 1'b1;
            w_cnt_clr = 1'b1;
          end
        end
        PIX1: begin
          // A sof here abandons the held even pixel; the sof beat becomes pixel 0.
          if (s_sof_i) begin
            w_load_hold = 1'b1;
            w_err       = 1'b1;
            w_cnt_clr   = 1'b1;
          end else begin
            w_issue      = 1'b1;
            w_next_state = w_last ? WAIT_SOF : PIX0;
          end
        end
        default: w_next_state = WAIT_SOF;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_hold       <= '0;
      r_cnt        <= '0;
      wr_addr_o    <= '0;
      wr_d_o       <= '0;
      wr_en_o      <= 1'b0;
      frame_done_o <= 1'b0;
      sync_err_o   <= 1'b0;
    end else begin
      wr_en_o      <= w_issue;
      frame_done_o <= w_issue & w_last;
      sync_err_o   <= w_err;
      if (w_load_hold) begin
        r_hold <= pixel_t'(s_data_i);
      end
      if (w_issue) begin
        wr_d_o    <= pack_uyvy(r_hold, pixel_t'(s_data_i));
        wr_addr_o <= r_cnt;
        r_cnt     <= w_last ? '0 : r_cnt + 1'b1;
      end else if (w_cnt_clr) begin
        r_cnt <= '0;
      end
    end
  end

endmodule
